// File: rtl/hc_sr_pkg.sv
// hc_sr_pkg: shared widths, default thresholds, FSM encoding and small helpers
// for the ultrasonic distance filter.
//   DIST_W : width of a distance word (cm x 1000)
//   SUM_W  : width of the 4-tap running sum (4 x 400000 < 2^21)
package hc_sr_pkg;

  localparam int DIST_W = 19;
  localparam int SUM_W  = 21;

  localparam int unsigned SAMPLE_CYC_DEF = 3_000_000;
  localparam int unsigned MAX_VALID_DEF  = 400_000;
  localparam int unsigned NEAR_TH_DEF    = 30_000;
  localparam int unsigned FAR_TH_DEF     = 40_000;
  localparam int unsigned FAULT_CNT_DEF  = 4;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_RUN   = 2'd1,
    ST_FAULT = 2'd2
  } state_e;

  // Hysteresis: assert below near_th, release above far_th, hold in between
  // (equality with either threshold holds).
  function automatic logic hyst_next(input logic [DIST_W-1:0] avg,
                                     input logic [DIST_W-1:0] near_th,
                                     input logic [DIST_W-1:0] far_th,
                                     input logic              cur);
    if (avg < near_th) return 1'b1;
    if (avg > far_th)  return 1'b0;
    return cur;
  endfunction

endpackage

// File: rtl/hc_sr_tick.sv
// hc_sr_tick: free-running sample-rate counter.
//   clk, rst_n : clock, async active-low reset
//   clr        : synchronous restart of the count at 0
//   tick       : high for the one cycle in which the count equals SAMPLE_CYC-1
// SAMPLE_CYC must be at least 4.
module hc_sr_tick #(
  parameter int unsigned SAMPLE_CYC = 3_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic tick
);

  localparam int CNT_W = $clog2(SAMPLE_CYC);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(SAMPLE_CYC - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign tick = (cnt_q == LAST);

  always_comb begin
    // NOTE: next-state logic assigns every output on every path (default
    // first, overrides after) so no latch can be inferred.
    cnt_d = cnt_q + 1'b1;
    if (tick) cnt_d = '0;
    if (clr)  cnt_d = '0;
  end

  // NOTE: state flops use non-blocking assignments only, so every flop samples
  // the pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/hc_sr_filter.sv
// hc_sr_filter: samples the hc_sr_driver distance once per tick, rejects
// readings of 0 or above MAX_VALID, keeps a 4-tap moving average and drives
// hysteresis obstacle and sensor-fault flags.
//   clk, rst_n : clock, async active-low reset
//   clr        : synchronous clear back to EMPTY (wins over a same-cycle tick)
//   data_i     : distance in cm x 1000, synchronous to clk
//   dist_avg   : filtered distance in cm x 1000
//   avg_vld    : one-cycle pulse when dist_avg is (re)issued
//   obstacle   : hysteresis obstacle flag (forced high while faulted)
//   fault      : sensor fault level
// Timing: tick in cycle T, sample captured at the end of T, filter/FSM and all
// outputs registered at the end of T+1, so avg_vld is high in cycle T+2.
module hc_sr_filter
  import hc_sr_pkg::*;
#(
  parameter int unsigned SAMPLE_CYC = SAMPLE_CYC_DEF,
  parameter int unsigned MAX_VALID  = MAX_VALID_DEF,
  parameter int unsigned NEAR_TH    = NEAR_TH_DEF,
  parameter int unsigned FAR_TH     = FAR_TH_DEF,
  parameter int unsigned FAULT_CNT  = FAULT_CNT_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic [DIST_W-1:0] data_i,
  output logic [DIST_W-1:0] dist_avg,
  output logic              avg_vld,
  output logic              obstacle,
  output logic              fault
);

  localparam logic [DIST_W-1:0] MAX_L   = DIST_W'(MAX_VALID);
  localparam logic [DIST_W-1:0] NEAR_L  = DIST_W'(NEAR_TH);
  localparam logic [DIST_W-1:0] FAR_L   = DIST_W'(FAR_TH);
  localparam logic [3:0]        FAULT_L = 4'(FAULT_CNT);

  logic tick;

  hc_sr_tick #(.SAMPLE_CYC(SAMPLE_CYC)) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .tick  (tick)
  );

  // Stage 1: sample capture and classification.
  logic [DIST_W-1:0] samp_q, samp_d;
  logic              samp_ok_q, samp_ok_d;
  logic              samp_pend_q, samp_pend_d;

  // Stage 2: window, FSM and outputs.
  logic [DIST_W-1:0] taps_q [4];
  logic [DIST_W-1:0] taps_d [4];
  logic [SUM_W-1:0]  sum_q, sum_d;
  logic [3:0]        inv_cnt_q, inv_cnt_d;
  state_e            state_q, state_d;
  logic [DIST_W-1:0] dist_avg_q, dist_avg_d;
  logic              avg_vld_q, avg_vld_d;
  logic              obstacle_q, obstacle_d;
  logic              fault_q, fault_d;

  logic [3:0]        inv_sat;
  logic [SUM_W-1:0]  sum_run;

  always_comb begin
    samp_d      = samp_q;
    samp_ok_d   = samp_ok_q;
    samp_pend_d = tick & ~clr;
    if (tick) begin
      samp_d    = data_i;
      samp_ok_d = (data_i != '0) && (data_i <= MAX_L);
    end

    taps_d     = taps_q;
    sum_d      = sum_q;
    inv_cnt_d  = inv_cnt_q;
    state_d    = state_q;
    dist_avg_d = dist_avg_q;
    avg_vld_d  = 1'b0;
    obstacle_d = obstacle_q;
    fault_d    = fault_q;

    inv_sat = (inv_cnt_q == FAULT_L) ? inv_cnt_q : inv_cnt_q + 4'd1;
    // The sum always equals the sum of the taps, so the subtraction cannot
    // underflow in practice; modular arithmetic would still be exact.
    sum_run = sum_q + SUM_W'(samp_q) - SUM_W'(taps_q[3]);

    if (samp_pend_q) begin
      if (samp_ok_q) begin
        inv_cnt_d = '0;
        fault_d   = 1'b0;
        avg_vld_d = 1'b1;
        state_d   = ST_RUN;
        if (state_q == ST_RUN) begin
          taps_d[3]  = taps_q[2];
          taps_d[2]  = taps_q[1];
          taps_d[1]  = taps_q[0];
          taps_d[0]  = samp_q;
          sum_d      = sum_run;
          dist_avg_d = sum_run[SUM_W-1:2];
        end else begin
          // EMPTY or FAULT: prime the whole window with the first good sample.
          taps_d     = '{default: samp_q};
          sum_d      = {samp_q, 2'b00};
          dist_avg_d = samp_q;
        end
        obstacle_d = hyst_next(dist_avg_d, NEAR_L, FAR_L, obstacle_q);
      end else begin
        inv_cnt_d = inv_sat;
        if (inv_sat == FAULT_L) begin
          // The sample that trips the fault is reported through fault, not
          // through avg_vld, so consumers never see a pulse with fault set.
          state_d    = ST_FAULT;
          fault_d    = 1'b1;
          obstacle_d = 1'b1;
        end else if (state_q == ST_RUN) begin
          avg_vld_d  = 1'b1;
          obstacle_d = hyst_next(dist_avg_q, NEAR_L, FAR_L, obstacle_q);
        end
      end
    end

    if (clr) begin
      samp_d      = '0;
      samp_ok_d   = 1'b0;
      taps_d      = '{default: '0};
      sum_d       = '0;
      inv_cnt_d   = '0;
      state_d     = ST_EMPTY;
      dist_avg_d  = '0;
      avg_vld_d   = 1'b0;
      obstacle_d  = 1'b0;
      fault_d     = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      samp_q      <= '0;
      samp_ok_q   <= 1'b0;
      samp_pend_q <= 1'b0;
      // NOTE: the window is four flops, not a RAM, so it is reset along with
      // everything else and the sum invariant holds from the first cycle.
      taps_q      <= '{default: '0};
      sum_q       <= '0;
      inv_cnt_q   <= '0;
      state_q     <= ST_EMPTY;
      dist_avg_q  <= '0;
      avg_vld_q   <= 1'b0;
      obstacle_q  <= 1'b0;
      fault_q     <= 1'b0;
    end else begin
      samp_q      <= samp_d;
      samp_ok_q   <= samp_ok_d;
      samp_pend_q <= samp_pend_d;
      taps_q      <= taps_d;
      sum_q       <= sum_d;
      inv_cnt_q   <= inv_cnt_d;
      state_q     <= state_d;
      dist_avg_q  <= dist_avg_d;
      avg_vld_q   <= avg_vld_d;
      obstacle_q  <= obstacle_d;
      fault_q     <= fault_d;
    end
  end

  assign dist_avg = dist_avg_q;
  assign avg_vld  = avg_vld_q;
  assign obstacle = obstacle_q;
  assign fault    = fault_q;

endmodule

// File: doc/hc_sr_filter.md
Name: hc_sr_filter

Overview:
Downstream consumer of the ultrasonic ranging driver's 19-bit distance word, in cm × 1000 (3 implied decimals).
- Samples the distance at a fixed rate and rejects out-of-range readings.
- Applies a 4-tap moving average to accepted samples.
- Drives a hysteresis obstacle flag and a sensor-fault flag for the robot motion-control FSM.
- Sits between hc_sr_driver and the obstacle-avoidance/motor logic.

Parameters:
- SAMPLE_CYC, 3_000_000: Clk cycles per sample tick (60 ms at 50 MHz). Must be ≥ 4.
- MAX_VALID, 400_000: largest accepted distance (400.000 cm). Readings of 0 or > MAX_VALID are invalid.
- NEAR_TH, 30_000: obstacle asserts when avg < NEAR_TH (30.000 cm).
- FAR_TH, 40_000: obstacle deasserts when avg > FAR_TH. Must satisfy NEAR_TH < FAR_TH ≤ MAX_VALID.
- FAULT_CNT, 4: consecutive invalid samples that declare a sensor fault (range 1..15).

Ports:
- Clk, in, 1: system clock, 50 MHz. Single clock domain.
- Rst_n, in, 1: asynchronous active-low reset.
- clr, in, 1: synchronous clear; returns the block to EMPTY.
- data_i, in, 19: distance from the driver (cm × 1000). Already synchronous to Clk.
- dist_avg, out, 19: filtered distance (cm × 1000).
- avg_vld, out, 1: one-cycle pulse when dist_avg updates.
- obstacle, out, 1: hysteresis obstacle flag.
- fault, out, 1: sensor fault, level.

Behaviour:
- Reset (Rst_n low, async), all outputs and state cleared:
  - dist_avg=0, avg_vld=0, obstacle=0, fault=0.
  - taps=0, sum=0, tick counter=0, invalid counter=0, FSM=EMPTY.
- clr (synchronous) has the same effect as reset, except the tick counter also restarts at 0. clr has priority over a tick in the same cycle.
- Tick counter: counts 0..SAMPLE_CYC-1 and wraps. tick=1 in the cycle where cnt==SAMPLE_CYC-1.
- Pipeline timing, with the tick at cycle T:
  - T: data_i is registered and classified valid/invalid.
  - T+1: taps, sum and invalid counter update; FSM transitions.
  - T+2: dist_avg, avg_vld, obstacle and fault update.
  - Fixed latency is 2 cycles from tick to avg_vld.
- Filter:
  - 4×19-bit shift register taps[0..3] and a 21-bit running sum.
  - An accepted sample s in RUN updates sum ← sum + s − taps[3], shifts taps, and gives dist_avg = sum[20:2] (truncating divide by 4).
  - Sum never overflows: 4 × 400000 < 2^21.
- FSM states:
  - EMPTY: window holds no data. A valid sample loads all 4 taps with s, sets sum = 4s, → RUN, avg_vld pulses with dist_avg = s. An invalid sample increments the invalid counter and stays in EMPTY; no avg_vld.
  - RUN: a valid sample updates the filter as above and clears the invalid counter. An invalid sample leaves taps/sum unchanged, increments the invalid counter, and avg_vld still pulses, repeating the held dist_avg. Invalid counter reaching FAULT_CNT → FAULT.
  - FAULT: fault=1 and obstacle forced to 1 (safe stop). dist_avg holds and no avg_vld is issued. The first valid sample reloads all taps with s (as in EMPTY), clears fault and the counter, → RUN, pulses avg_vld, and re-evaluates obstacle from s.
  - The EMPTY → FAULT transition also occurs after FAULT_CNT invalid samples.
- Invalid counter saturates at FAULT_CNT; no wrap.
- Hysteresis is evaluated on the new dist_avg whenever avg_vld pulses:
  - dist_avg < NEAR_TH → obstacle = 1.
  - dist_avg > FAR_TH → obstacle = 0.
  - Otherwise obstacle holds.
  - Equality with either threshold holds the current state.
- Boundary samples: data_i == MAX_VALID is valid; data_i == 0 is invalid.
- data_i changing between ticks is ignored; only the value present at the tick is used.

Decomposition:
- Shared package hc_sr_pkg holds:
  - DIST_W = 19 and SUM_W = 21.
  - Default threshold and MAX_VALID constants.
  - FSM state encoding: EMPTY = 2'd0, RUN = 2'd1, FAULT = 2'd2.
- One natural sub-module, hc_sr_tick: a parameterised SAMPLE_CYC counter with clr, producing the tick pulse.
- Filter, FSM and hysteresis stay in hc_sr_filter.

Test Plan:
All scenarios use SAMPLE_CYC=10 with other parameters at default.
- Reset/first sample: release Rst_n with data_i=50000 → first avg_vld 2 cycles after the first tick, dist_avg=50000, obstacle=0, fault=0.
- Averaging: from a 50000 steady state, apply 10000 for 4 ticks → dist_avg sequence 40000, 30000, 20000, 10000. obstacle stays 0 at 30000 (equals NEAR_TH) and asserts at 20000.
- Hysteresis: with obstacle=1 and dist_avg≈10000, step input to 40000 → obstacle stays 1 through dist_avg 17500, 25000, 32500, 40000 (equals FAR_TH). Then input 44000 gives dist_avg 41000 → obstacle deasserts.
- Invalid rejection: in RUN at 50000, inject one sample of 0 and one of 400001 → dist_avg repeats 50000 with avg_vld pulsing, fault=0. The next valid 50000 clears the invalid counter.
- Fault entry/exit: 4 consecutive 0 samples → fault=1 and obstacle=1 after the 4th; no avg_vld in FAULT. Then a valid 80000 → fault=0, dist_avg=80000, obstacle=0.
- Mid-operation reset/clr: assert Rst_n low asynchronously between ticks → all outputs 0 immediately. Pulse clr coincident with a tick → tick ignored, state EMPTY, no avg_vld.
